id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage directly upstream of the ALU in the pipelined MIPS datapath. Registers decoded operands and control from the decode stage and converts ALUOp/funct into the 4-bit ALUCon code. Resolves EX/MEM and MEM/WB forwarding onto ALU operands `a`/`b`, and detects load-use hazards, inserting a bubble when one occurs. Outputs drive the ALU's `ALUCon`, `a` and `b` inputs and the EX/MEM register.

## Interface
- `WIDTH`, 32, datapath width
- `clk` input 1: single clock, rising edge
- `reset` input 1: synchronous, active-high
- `id_valid` input 1: decode holds a real instruction
- `id_rs_addr`, `id_rt_addr`, `id_rd_addr` input 5 each: register specifiers
- `id_rs_data`, `id_rt_data` input WIDTH: register-file read data
- `id_imm` input WIDTH: immediate, already extended by decode
- `id_aluop` input 2: 00 add, 01 sub, 10 R-type (use funct), 11 immediate-logic (use opcode)
- `id_funct`, `id_opcode` input 6 each
- `id_alusrc`, `id_regdst`, `id_regwrite`, `id_memread`, `id_memwrite`, `id_memtoreg`, `id_uses_rt` input 1 each
- `stall_in` input 1: downstream hold; freeze stage contents
- `flush_in` input 1: kill the instruction being captured (branch redirect)
- `exmem_regwrite` input 1, `exmem_rd` input 5, `exmem_result` input WIDTH
- `memwb_regwrite` input 1, `memwb_rd` input 5, `memwb_result` input WIDTH
- `ALUCon` output 4: registered ALU control
- `a`, `b` output WIDTH: forwarded ALU operands (combinational from registered state)
- `ex_store_data` output WIDTH: forwarded rt value for stores
- `ex_dest` output 5: rd if regdst else rt
- `ex_valid`, `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_memtoreg` output 1
- `hazard_stall` output 1: upstream (PC and IF/ID) must hold this cycle

## Operation
- ALUCon decode on capture: aluop 00→0010; 01→0110; 10 with funct 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111, any other funct→1111; 11 with opcode 001100 (andi)→0000, 001101 (ori)→0001, 001010 (slti)→0111, any other opcode→1111. The ALU outputs 0 for 1111.
- Bubble contents: valid, regwrite, memread, memwrite, memtoreg = 0; ALUCon = 0010; all data and address fields = 0.
- Load-use hazard: `hazard_stall` = ex_valid & ex_memread & ex_rt≠0 & (ex_rt==id_rs_addr | (id_uses_rt & ex_rt==id_rt_addr)). Combinational from ID inputs and registered EX state.
- Per-operand forwarding, for rs and rt independently:
  - select exmem_result if exmem_regwrite & exmem_rd≠0 & exmem_rd==addr;
  - else memwb_result under the same rule;
  - else registered data. EX/MEM has priority.
- `a` = forwarded rs. `b` = alusrc ? registered imm : forwarded rt. `ex_store_data` = forwarded rt always.
- Register $0 is never forwarded.

## Timing
- Every `ex_*` field, `ALUCon` and the data registers update only on the rising clk edge. Priority, highest first:
  1. `reset` → bubble.
  2. `stall_in` → hold all contents, even if flush or hazard is active.
  3. `flush_in` | `hazard_stall` → bubble.
  4. Otherwise capture ID inputs, with valid = id_valid.
- Latency: an instruction presented on ID in cycle N reaches `ALUCon`/`a`/`b` in cycle N+1, unless it is stalled.
- After reset, all outputs read as bubble values: a = 0, b = 0, ALUCon = 0010, `hazard_stall` = 0.
- Forwarding muxes and `hazard_stall` have zero cycles of latency; the bypass inputs are sampled in the same cycle they are used.
- When `hazard_stall` is asserted in cycle N:
  - one bubble is in EX at N+1;
  - the held instruction is captured at the N+1 edge, provided the hazard has cleared;
  - the load result arrives via the MEM/WB bypass.
- Reset asserted mid-stall overrides the stall. Reset asserted mid-hazard yields a bubble. No state persists across reset.

## Structure
- Package `mips_pkg`: ALUCon encodings (ALU_ADD 0010, ALU_SUB 0110, ALU_AND 0000, ALU_OR 0001, ALU_SLT 0111, ALU_NOP 1111), ALUOp codes, funct and opcode constants. These are shared with the ALU and the main control unit.
- Sub-module `alu_control`: purely combinational ALUOp/funct/opcode → ALUCon. Instantiated once and registered by this stage.
- Forwarding and hazard logic stay inline.

## Test plan
- R-type `sub` (funct 100010), rs = 7, rt = 3, no bypass → next cycle ALUCon = 0110, a = 7, b = 3; downstream ALU out = 4.
- Back-to-back dependency: exmem_rd = rs = 5, exmem_result = 0xAA, and memwb_rd = 5, memwb_result = 0xBB → a = 0xAA. With exmem_regwrite = 0 → a = 0xBB. With rd = 0 on both → a = registered data.
- Load-use: EX holds lw with rt = 8, ID rs = 8 → `hazard_stall` = 1. Next cycle EX is a bubble (regwrite = 0, ALUCon = 0010). The following edge captures the dependent instruction.
- `addi`-style (aluop 00, alusrc 1), imm = 0xFFFFFFFF, rs = 1 → ALUCon = 0010, b = 0xFFFFFFFF. `ex_store_data` still shows forwarded rt.
- `stall_in` and `flush_in` both high for 2 cycles → contents unchanged. Then `flush_in` alone → bubble. Unknown funct 001000 with aluop 10 → ALUCon = 1111.
- Reset asserted mid-stream with stall_in = 1 → next edge gives all outputs at bubble values and `hazard_stall` = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: ALU control codes, ALUOp classes, R-type funct and
// I-type opcode values used by the main control, the ALU and the ID/EX stage.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_IMM   = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  // Single-bit control carried from decode into EX; all-zero is a bubble.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic alusrc;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/alu_control.sv
// Combinational ALUOp/funct/opcode to 4-bit ALUCon translation.
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  input  logic [5:0] opcode_i,
  output logic [3:0] alucon_o
);

  always_comb begin
    alucon_o = ALU_NOP;
    case (aluop_i)
      ALUOP_ADD: alucon_o = ALU_ADD;
      ALUOP_SUB: alucon_o = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: alucon_o = ALU_ADD;
          FUNCT_SUB: alucon_o = ALU_SUB;
          FUNCT_AND: alucon_o = ALU_AND;
          FUNCT_OR:  alucon_o = ALU_OR;
          FUNCT_SLT: alucon_o = ALU_SLT;
          default:   alucon_o = ALU_NOP;
        endcase
      end
      ALUOP_IMM: begin
        case (opcode_i)
          OP_ANDI: alucon_o = ALU_AND;
          OP_ORI:  alucon_o = ALU_OR;
          OP_SLTI: alucon_o = ALU_SLT;
          default: alucon_o = ALU_NOP;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, EX/MEM and MEM/WB operand
// forwarding, and load-use hazard detection that inserts a single bubble.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [1:0]       id_aluop,
  input  logic [5:0]       id_funct,
  input  logic [5:0]       id_opcode,
  input  logic             id_alusrc,
  input  logic             id_regdst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             id_uses_rt,
  input  logic             stall_in,
  input  logic             flush_in,
  input  logic             exmem_regwrite,
  input  logic [4:0]       exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_regwrite,
  input  logic [4:0]       memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [3:0]       ALUCon,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [4:0]       ex_dest,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             hazard_stall
);

  ex_ctrl_t         ctrl_q, ctrl_d;
  logic [3:0]       alucon_q, alucon_d;
  logic [4:0]       rs_addr_q, rs_addr_d;
  logic [4:0]       rt_addr_q, rt_addr_d;
  logic [4:0]       dest_q, dest_d;
  logic [WIDTH-1:0] rs_data_q, rs_data_d;
  logic [WIDTH-1:0] rt_data_q, rt_data_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [3:0]       id_alucon;
  logic [WIDTH-1:0] fwd_rs, fwd_rt;

  alu_control u_alu_control (
    .aluop_i  (id_aluop),
    .funct_i  (id_funct),
    .opcode_i (id_opcode),
    .alucon_o (id_alucon)
  );

  // A load in EX cannot supply its result until MEM/WB, so a dependent
  // instruction in ID must wait one cycle behind a bubble.
  assign hazard_stall = ctrl_q.valid && ctrl_q.memread && (rt_addr_q != 5'd0) &&
                        ((rt_addr_q == id_rs_addr) ||
                         (id_uses_rt && (rt_addr_q == id_rt_addr)));

  always_comb begin
    ctrl_d    = ctrl_q;
    alucon_d  = alucon_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    dest_d    = dest_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    if (stall_in) begin
      ctrl_d = ctrl_q;
    end else if (flush_in || hazard_stall) begin
      ctrl_d    = CTRL_BUBBLE;
      alucon_d  = ALU_ADD;
      rs_addr_d = '0;
      rt_addr_d = '0;
      dest_d    = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
    end else begin
      ctrl_d.valid    = id_valid;
      ctrl_d.regwrite = id_regwrite;
      ctrl_d.memread  = id_memread;
      ctrl_d.memwrite = id_memwrite;
      ctrl_d.memtoreg = id_memtoreg;
      ctrl_d.alusrc   = id_alusrc;
      alucon_d        = id_alucon;
      rs_addr_d       = id_rs_addr;
      rt_addr_d       = id_rt_addr;
      dest_d          = id_regdst ? id_rd_addr : id_rt_addr;
      rs_data_d       = id_rs_data;
      rt_data_d       = id_rt_data;
      imm_d           = id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= CTRL_BUBBLE;
      alucon_q  <= ALU_ADD;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      dest_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      alucon_q  <= alucon_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      dest_q    <= dest_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
    end
  end

  // The younger EX/MEM result wins over MEM/WB; $0 is never bypassed.
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs_addr_q)) begin
      fwd_rs = exmem_result;
    end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs_addr_q)) begin
      fwd_rs = memwb_result;
    end
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rt_addr_q)) begin
      fwd_rt = exmem_result;
    end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rt_addr_q)) begin
      fwd_rt = memwb_result;
    end
  end

  assign a             = fwd_rs;
  assign b             = ctrl_q.alusrc ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ALUCon        = alucon_q;
  assign ex_dest       = dest_q;
  assign ex_valid      = ctrl_q.valid;
  assign ex_regwrite   = ctrl_q.regwrite;
  assign ex_memread    = ctrl_q.memread;
  assign ex_memwrite   = ctrl_q.memwrite;
  assign ex_memtoreg   = ctrl_q.memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: decode, forwarding, load-use
// bubbles, stall/flush priority and reset behaviour.
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [4:0]       id_rs_addr, id_rt_addr, id_rd_addr;
  logic [WIDTH-1:0] id_rs_data, id_rt_data, id_imm;
  logic [1:0]       id_aluop;
  logic [5:0]       id_funct, id_opcode;
  logic             id_alusrc, id_regdst, id_regwrite, id_memread;
  logic             id_memwrite, id_memtoreg, id_uses_rt;
  logic             stall_in, flush_in;
  logic             exmem_regwrite, memwb_regwrite;
  logic [4:0]       exmem_rd, memwb_rd;
  logic [WIDTH-1:0] exmem_result, memwb_result;
  logic [3:0]       ALUCon;
  logic [WIDTH-1:0] a, b, ex_store_data;
  logic [4:0]       ex_dest;
  logic             ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic             hazard_stall;

  id_ex_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_aluop(id_aluop), .id_funct(id_funct), .id_opcode(id_opcode),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_uses_rt(id_uses_rt), .stall_in(stall_in), .flush_in(flush_in),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ALUCon(ALUCon), .a(a), .b(b), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             valid, regwrite, memread, memwrite, memtoreg;
    logic [3:0]       alucon;
    logic [4:0]       dest;
    logic [WIDTH-1:0] a, b, store;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } exp_t;

  typedef struct {
    logic             valid;
    logic [4:0]       rs, rt, rd;
    logic [WIDTH-1:0] rsData, rtData, imm;
    logic [1:0]       aluop;
    logic [5:0]       funct, opcode;
    logic             alusrc, regdst, regwrite, memread, memwrite, memtoreg, usesRt;
  } instr_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  obs_t bubble;
  obs_t addiObs;
  obs_t lwObs;

  function automatic obs_t mkObs(input logic v, input logic rw, input logic mr,
                                 input logic mw, input logic mt, input logic [3:0] ac,
                                 input logic [4:0] d, input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] sv);
    obs_t o;
    o.valid = v; o.regwrite = rw; o.memread = mr; o.memwrite = mw; o.memtoreg = mt;
    o.alucon = ac; o.dest = d; o.a = av; o.b = bv; o.store = sv;
    return o;
  endfunction

  function automatic instr_t rType(input logic [4:0] rs, input logic [WIDTH-1:0] rsData,
                                   input logic [4:0] rt, input logic [WIDTH-1:0] rtData,
                                   input logic [4:0] rd, input logic [5:0] funct);
    instr_t i;
    i = '{valid: 1'b1, rs: rs, rt: rt, rd: rd, rsData: rsData, rtData: rtData, imm: '0,
          aluop: 2'b10, funct: funct, opcode: 6'b000000, alusrc: 1'b0, regdst: 1'b1,
          regwrite: 1'b1, memread: 1'b0, memwrite: 1'b0, memtoreg: 1'b0, usesRt: 1'b1};
    return i;
  endfunction

  function automatic instr_t iType(input logic [1:0] aluop, input logic [5:0] opcode,
                                   input logic [4:0] rs, input logic [WIDTH-1:0] rsData,
                                   input logic [4:0] rt, input logic [WIDTH-1:0] rtData,
                                   input logic [WIDTH-1:0] imm, input logic load);
    instr_t i;
    i = '{valid: 1'b1, rs: rs, rt: rt, rd: 5'd0, rsData: rsData, rtData: rtData, imm: imm,
          aluop: aluop, funct: 6'b000000, opcode: opcode, alusrc: 1'b1, regdst: 1'b0,
          regwrite: 1'b1, memread: load, memwrite: 1'b0, memtoreg: load, usesRt: 1'b0};
    return i;
  endfunction

  task automatic applyStimulus(input instr_t i);
    id_valid = i.valid; id_rs_addr = i.rs; id_rt_addr = i.rt; id_rd_addr = i.rd;
    id_rs_data = i.rsData; id_rt_data = i.rtData; id_imm = i.imm;
    id_aluop = i.aluop; id_funct = i.funct; id_opcode = i.opcode;
    id_alusrc = i.alusrc; id_regdst = i.regdst; id_regwrite = i.regwrite;
    id_memread = i.memread; id_memwrite = i.memwrite; id_memtoreg = i.memtoreg;
    id_uses_rt = i.usesRt;
  endtask

  task automatic setBypass(input logic xrw, input logic [4:0] xrd, input logic [WIDTH-1:0] xres,
                           input logic mrw, input logic [4:0] mrd, input logic [WIDTH-1:0] mres);
    exmem_regwrite = xrw; exmem_rd = xrd; exmem_result = xres;
    memwb_regwrite = mrw; memwb_rd = mrd; memwb_result = mres;
  endtask

  task automatic expectNext(input string tag, input obs_t v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput();
    exp_t e;
    obs_t o;
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $error("[TB] FAIL scoreboard_empty: observed=none expected=entry");
    end else begin
      e = sb.pop_front();
      o = mkObs(ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
                ALUCon, ex_dest, a, b, ex_store_data);
      assert (o === e.v) passes++;
      else begin
        fails++;
        $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, o, e.v);
      end
    end
  endtask

  task automatic checkHazard(input string tag, input logic expected);
    checks++;
    assert (hazard_stall === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, hazard_stall, expected);
    end
  endtask

  logic [1:0] tAluop  [8] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
  logic [5:0] tFunct  [8] = '{6'b000000, 6'b100100, 6'b100101, 6'b101010,
                              6'b000000, 6'b000000, 6'b000000, 6'b000000};
  logic [5:0] tOpcode [8] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
                              6'b001100, 6'b001101, 6'b001010, 6'b000000};
  logic [3:0] tAlucon [8] = '{4'b0110, 4'b0000, 4'b0001, 4'b0111,
                              4'b0000, 4'b0001, 4'b0111, 4'b1111};

  initial begin
    instr_t ins;
    bubble  = mkObs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 5'd0, '0, '0, '0);
    addiObs = mkObs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 5'd11, 32'h10, 32'hFFFFFFFF, 32'h77);
    lwObs   = mkObs(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 5'd8, 32'h100, 32'd4, 32'h0);

    reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
    applyStimulus(rType(5'd0, '0, 5'd0, '0, 5'd0, FUNCT_ADD));
    setBypass(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    tick(); tick();
    expectNext("reset_bubble", bubble);
    checkOutput();
    checkHazard("reset_hazard", 1'b0);
    reset = 1'b0;

    applyStimulus(rType(5'd1, 32'd7, 5'd2, 32'd3, 5'd4, FUNCT_SUB));
    expectNext("sub", mkObs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 5'd4, 32'd7, 32'd3, 32'd3));
    tick();
    checkOutput();
    checks++;
    assert ((a - b) === 32'd4) passes++;
    else begin
      fails++;
      $error("[TB] FAIL sub_alu_result: observed=%h expected=%h", a - b, 32'd4);
    end

    applyStimulus(rType(5'd5, 32'h11, 5'd6, 32'h22, 5'd7, FUNCT_ADD));
    tick();
    setBypass(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB); #1;
    expectNext("fwd_exmem_priority", mkObs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 5'd7, 32'hAA, 32'h22, 32'h22));
    checkOutput();
    setBypass(1'b0, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB); #1;
    expectNext("fwd_memwb", mkObs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 5'd7, 32'hBB, 32'h22, 32'h22));
    checkOutput();
    setBypass(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB); #1;
    expectNext("fwd_r0_blocked", mkObs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 5'd7, 32'h11, 32'h22, 32'h22));
    checkOutput();
    setBypass(1'b1, 5'd6, 32'hCC, 1'b1, 5'd5, 32'hBB); #1;
    expectNext("fwd_split_rs_rt", mkObs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 5'd7, 32'hBB, 32'hCC, 32'hCC));
    checkOutput();
    setBypass(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    applyStimulus(iType(2'b00, OP_LW, 5'd9, 32'h100, 5'd8, 32'h0, 32'd4, 1'b1));
    expectNext("lw", lwObs);
    tick();
    checkOutput();
    ins = rType(5'd3, 32'h0, 5'd8, 32'h3, 5'd10, FUNCT_ADD);
    applyStimulus(ins); #1;
    checkHazard("loaduse_rt", 1'b1);
    ins.usesRt = 1'b0;
    applyStimulus(ins); #1;
    checkHazard("loaduse_rt_unused", 1'b0);
    applyStimulus(rType(5'd8, 32'h0, 5'd2, 32'h3, 5'd10, FUNCT_ADD)); #1;
    checkHazard("loaduse_rs", 1'b1);
    tick();
    expectNext("hazard_bubble", bubble);
    checkOutput();
    checkHazard("hazard_cleared", 1'b0);
    tick();
    setBypass(1'b0, 5'd0, '0, 1'b1, 5'd8, 32'h55); #1;
    expectNext("loaduse_memwb_fwd", mkObs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 5'd10, 32'h55, 32'h3, 32'h3));
    checkOutput();
    setBypass(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    applyStimulus(iType(2'b00, OP_ADDI, 5'd1, 32'h10, 5'd11, 32'h33, 32'hFFFFFFFF, 1'b0));
    tick();
    setBypass(1'b1, 5'd11, 32'h77, 1'b0, 5'd0, '0); #1;
    expectNext("addi_imm", addiObs);
    checkOutput();

    applyStimulus(iType(2'b11, OP_ORI, 5'd2, 32'h5, 5'd12, 32'h0, 32'h1, 1'b0));
    stall_in = 1'b1; flush_in = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      expectNext("stall_flush_hold", addiObs);
      checkOutput();
    end
    stall_in = 1'b0;
    tick();
    expectNext("flush_bubble", bubble);
    checkOutput();
    flush_in = 1'b0;
    setBypass(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    applyStimulus(rType(5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 6'b001000));
    expectNext("funct_unknown", mkObs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 5'd3, 32'h1, 32'h2, 32'h2));
    tick();
    checkOutput();

    for (int k = 0; k < 8; k++) begin
      ins = rType(5'd1, 32'h1, 5'd2, 32'h2, 5'd3, tFunct[k]);
      ins.aluop  = tAluop[k];
      ins.opcode = tOpcode[k];
      applyStimulus(ins);
      expectNext($sformatf("alucon_%0d", k),
                 mkObs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tAlucon[k], 5'd3, 32'h1, 32'h2, 32'h2));
      tick();
      checkOutput();
    end

    applyStimulus(iType(2'b00, OP_LW, 5'd9, 32'h100, 5'd0, 32'h0, 32'd4, 1'b1));
    expectNext("lw_r0", mkObs(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 5'd0, 32'h100, 32'd4, 32'h0));
    tick();
    checkOutput();
    applyStimulus(rType(5'd0, 32'h0, 5'd0, 32'h0, 5'd10, FUNCT_ADD)); #1;
    checkHazard("lw_r0_no_hazard", 1'b0);

    applyStimulus(iType(2'b00, OP_LW, 5'd9, 32'h100, 5'd8, 32'h0, 32'd4, 1'b1));
    expectNext("lw_again", lwObs);
    tick();
    checkOutput();
    applyStimulus(rType(5'd8, 32'h0, 5'd2, 32'h3, 5'd10, FUNCT_ADD));
    stall_in = 1'b1; #1;
    checkHazard("hazard_under_stall", 1'b1);
    tick();
    expectNext("stall_over_hazard", lwObs);
    checkOutput();
    reset = 1'b1;
    tick();
    expectNext("reset_mid_stall", bubble);
    checkOutput();
    checkHazard("reset_mid_hazard", 1'b0);
    reset = 1'b0; stall_in = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
